// File: rtl/shift_add_multiplier32_if.sv
// rtl/shift_add_multiplier32_if.sv - start/busy/done handshake and operand/product bundle for the MUL unit
interface shift_add_multiplier32_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] P;

  // Requester side: issues operands and start, observes status and product
  modport master (
    output start, A, B,
    input  busy, done, P
  );

  // Multiplier side
  modport slave (
    input  start, A, B,
    output busy, done, P
  );
endinterface

// File: rtl/shift_add_multiplier32.sv
// rtl/shift_add_multiplier32.sv - sequential 32x32->64 unsigned shift-add multiplier around ripple_adder32
module ripple_adder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples LSB to MSB
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[32];
endmodule

module shift_add_multiplier32 (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier32_if.slave bus
);
  localparam int WIDTH = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [5:0]         cnt;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;

  // Add the multiplicand into the upper half only when the current multiplier bit is set
  assign add_y = acc[0] ? mcand : '0;

  ripple_adder32 u_adder (
    .x    (acc[2*WIDTH-1:WIDTH]),
    .y    (add_y),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: 32 RUN cycles, then a single DONE cycle back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (cnt == 6'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, then add-then-shift with the carry landing in bit 63
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.A;
            acc   <= {{WIDTH{1'b0}}, bus.B};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= {add_cout, add_s, acc[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.P    = acc;
endmodule

// File: tb/tb_shift_add_multiplier32.sv
// tb/tb_shift_add_multiplier32.sv - directed and reference-model checks for shift_add_multiplier32
module tb_shift_add_multiplier32;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   edges;
  int   last_accept;

  shift_add_multiplier32_if mif ();

  shift_add_multiplier32 dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after done falls.
  // noise=1 pokes start during RUN (cycles 10..12) and during DONE, both of which must be ignored.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input bit noise);
    int n;
    int busy_cnt;
    int acc_edge;
    mif.start = 1'b1;
    mif.A     = a;
    mif.B     = b;
    @(negedge clk);
    acc_edge  = edges;
    mif.start = 1'b0;
    mif.A     = $urandom;
    mif.B     = $urandom;
    n        = 0;
    busy_cnt = 0;
    while (mif.done !== 1'b1 && n < 40) begin
      if (mif.busy === 1'b1) busy_cnt++;
      if (noise && n == 10) begin
        mif.start = 1'b1;
        mif.A     = 32'd100;
        mif.B     = 32'd100;
      end
      if (noise && n == 13) mif.start = 1'b0;
      n++;
      @(negedge clk);
    end
    check("latency", 64'(n), 64'd32);
    check("busy_cycles", 64'(busy_cnt), 64'd32);
    check("busy_low_at_done", {63'b0, mif.busy}, 64'd0);
    check("product", mif.P, exp);
    if (noise) mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    check("done_pulse_end", {63'b0, mif.done}, 64'd0);
    check("busy_after_done", {63'b0, mif.busy}, 64'd0);
    check("product_held", mif.P, exp);
    if (noise) begin
      @(negedge clk);
      check("start_in_done_ignored", {63'b0, mif.busy}, 64'd0);
    end
    if (last_accept >= 0 && !noise) last_accept = acc_edge - last_accept;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          first_acc;
    n_cmp       = 0;
    n_bad       = 0;
    edges       = 0;
    last_accept = -1;
    rst         = 1'b1;
    mif.start   = 1'b0;
    mif.A       = '0;
    mif.B       = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, mif.busy}, 64'd0);
    check("rst_done", {63'b0, mif.done}, 64'd0);
    check("rst_P", mif.P, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {63'b0, mif.busy}, 64'd0);

    run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b0);
    run_mul(32'd0, 32'hDEAD_BEEF, 64'd0, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 64'd0, 1'b0);
    run_mul(32'd7, 32'd9, 64'd63, 1'b1);

    // Reset in the middle of an all-ones multiply
    mif.start = 1'b1;
    mif.A     = 32'hFFFF_FFFF;
    mif.B     = 32'hFFFF_FFFF;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_busy", {63'b0, mif.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", {63'b0, mif.busy}, 64'd0);
    check("async_rst_done", {63'b0, mif.done}, 64'd0);
    check("async_rst_P", mif.P, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_mul(32'd6, 32'd7, 64'd42, 1'b0);

    // Back-to-back at the earliest legal edges
    last_accept = -1;
    mif.start = 1'b1;
    mif.A     = 32'd10;
    mif.B     = 32'd20;
    @(negedge clk);
    first_acc = edges;
    mif.start = 1'b0;
    repeat (32) @(negedge clk);
    check("b2b_first_done", {63'b0, mif.done}, 64'd1);
    check("b2b_first_P", mif.P, 64'd200);
    @(negedge clk);
    last_accept = first_acc;
    run_mul(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    check("b2b_spacing", 64'(last_accept), 64'd34);
    last_accept = -1;

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      if (i == 1) rb = 32'h8000_0001;
      run_mul(ra, rb, {32'b0, ra} * {32'b0, rb}, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier32.md
# shift_add_multiplier32

Sequential unsigned 32x32 -> 64-bit multiplier built around one instance of the team's `ripple_adder32`. The multiplier supplies the adder's X/Y/Cin operands each cycle and consumes its S/Cout outputs, retiring one multiplier bit per clock. It sits beside the combinational ALU as the multi-cycle MUL unit and uses a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand width. This is fixed at 32 to match `ripple_adder32`; no other value is supported.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `A` in 32: multiplicand. Captured on the accepting edge.
- `B` in 32: multiplier. Captured on the accepting edge.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when the product is valid.
- `P` out 64: product register. Holds its value until the next accepted start.

## Operation
- Registers:
  - `mcand[31:0]`
  - `acc[63:0]`, where `acc[63:32]` is the running upper half and `acc[31:0]` holds the remaining multiplier bits
  - `cnt[5:0]`
  - `state` ∈ {IDLE, RUN, DONE}
- Adder hookup:
  - X = `acc[63:32]`
  - Y = `acc[0]` ? `mcand` : 32'b0
  - Cin = 0
- IDLE with `start`=1:
  - load `mcand`←A, `acc`←{32'b0, B}, `cnt`←0
  - go to RUN
- IDLE with `start`=0: no change.
- RUN, each edge:
  - `acc` ← {Cout, S, `acc[31:1]`}, which is add-then-shift-right by 1 with the carry entering bit 63
  - `cnt` ← `cnt`+1
  - when `cnt` reaches 31 (this edge performs the 32nd iteration), go to DONE
- DONE: on the next edge, return to IDLE.
- `P` is driven from `acc` and is valid from the edge entering DONE.
- `start` is ignored in RUN and DONE. Operands are not re-sampled, and no queuing or error flag exists.
- A/B may change freely after the accepting edge.
- Arithmetic:
  - exact unsigned product, with no overflow possible (max 0xFFFFFFFE00000001)
  - no sign handling
  - adder Cout must be captured every iteration; dropping it corrupts results when `acc[63:32]`+`mcand` ≥ 2^32
- Reset (any time, including mid-RUN):
  - state←IDLE
  - `mcand`, `acc`, `cnt` ← 0
  - `busy`=0, `done`=0, `P`=64'b0
  - an in-flight operation is discarded

## Timing
- Edge E0: `start`=1 sampled in IDLE (load). `busy` rises after E0.
- Edges E1..E32: the 32 iterations. State enters DONE after E32. `busy` falls and `done` rises in the same cycle.
- Edge E33: DONE→IDLE. `done` falls.
- A new start may be sampled at E34 at the earliest, which gives a throughput of one multiply per 34 cycles.
- Latency from the accepting edge to `done` high is 32 cycles.
- `busy` and `done` are registered state decodes. They are never high together.
- The adder path is combinational within one cycle; the period must cover the 32-bit ripple carry.
- `P` is stable from E32 until the next accepting edge. During RUN, `P` shows intermediate `acc` values and must not be treated as valid.

## Test plan
- **Small operands:** A=3, B=5, start pulse.
  - `busy` high 32 cycles, then `done` one-cycle pulse.
  - P=64'h0000_0000_0000_000F, and it is held after `done`.
- **Carry stress:** A=B=32'hFFFF_FFFF.
  - P=64'hFFFF_FFFE_0000_0001.
  - Also A=32'h8000_0000, B=2 → P=64'h0000_0001_0000_0000.
- **Zero operands:**
  - A=0, B=32'hDEAD_BEEF → P=0.
  - A=32'h1234_5678, B=0 → P=0.
  - The timing of `busy`/`done` is identical to the non-zero cases.
- **Start while busy:**
  - Start A=7, B=9.
  - At cycle 10, assert start with A=100, B=100 and hold for 3 cycles.
  - Result is P=63, and `done` comes at the original time.
  - A start asserted while DONE is also ignored.
- **Reset mid-operation:**
  - Assert `rst` at iteration 15 of A=B=32'hFFFF_FFFF.
  - Immediately (asynchronously, before the next edge): `busy`=0, `done`=0, P=0.
  - After release, A=6, B=7 gives P=42 with full 32-cycle latency.
- **Back-to-back:**
  - Issue starts at the earliest legal edges: A=10, B=20, then A=32'hFFFF_FFFF, B=1.
  - Results are P=200, then P=64'h0000_0000_FFFF_FFFF.
  - Exactly 34 cycles separate the two accepting edges.
  - Compare against a `A*B` reference over 1000 random pairs.
